// File: rtl/milano_pkg.sv
// Shared register-file constants and writeback types.
package milano_pkg;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_PEND,
    WB_SRC_LSU
  } wb_src_e;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_write_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Busy bits for registers awaiting a load writeback.
module wb_scoreboard
  import milano_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy
);
  logic [NUM_REGS-1:0] busy_q;

  // Set is applied after clear so a same-cycle set of the same address wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (clr_en)
        busy_q[clr_addr] <= 1'b0;
      if (set_en && (set_addr != '0))
        busy_q[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    rs1_busy = busy_q[rs1_addr] && !(clr_en && (clr_addr == rs1_addr));
    rs2_busy = busy_q[rs2_addr] && !(clr_en && (clr_addr == rs2_addr));
  end
endmodule

// File: rtl/wb_regfile.sv
// Integer register file with ALU and load writeback ports, a one-entry
// load holding buffer, write-through reads and a load scoreboard.
module wb_regfile
  import milano_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_we_i,
  input  logic [REG_AW-1:0] alu_waddr_i,
  input  logic [XLEN-1:0]   alu_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [REG_AW-1:0] lsu_waddr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic              lsu_issue_i,
  input  logic [REG_AW-1:0] lsu_issue_addr_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_rdata_o,
  output logic [XLEN-1:0]   rs2_rdata_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);
  logic [XLEN-1:0]   regs [1:NUM_REGS-1];
  logic              pend_valid;
  logic [REG_AW-1:0] pend_addr;
  logic [XLEN-1:0]   pend_data;

  logic              alu_we;
  logic              lsu_xfer;
  logic              pend_kill;
  logic              clr_en;
  logic [REG_AW-1:0] clr_addr;
  wb_src_e           src;
  wb_write_t         wr;

  assign lsu_ready_o = !pend_valid && !rst_i;
  assign alu_we      = alu_we_i && !rst_i;
  assign lsu_xfer    = lsu_valid_i && lsu_ready_o;
  assign pend_kill   = pend_valid && alu_we && (alu_waddr_i == pend_addr) && (pend_addr != '0);

  always_comb begin
    src = WB_SRC_NONE;
    if (alu_we)          src = WB_SRC_ALU;
    else if (pend_valid) src = WB_SRC_PEND;
    else if (lsu_xfer)   src = WB_SRC_LSU;
  end

  always_comb begin
    wr = '0;
    unique case (src)
      WB_SRC_ALU:  begin wr.addr = alu_waddr_i; wr.data = alu_wdata_i; end
      WB_SRC_PEND: begin wr.addr = pend_addr;   wr.data = pend_data;   end
      WB_SRC_LSU:  begin wr.addr = lsu_waddr_i; wr.data = lsu_wdata_i; end
      default:     ;
    endcase
    wr.en = (src != WB_SRC_NONE) && (wr.addr != '0);
  end

  // A load's busy bit clears when its data reaches the array or is superseded.
  assign clr_en   = (src == WB_SRC_PEND) || (src == WB_SRC_LSU) || pend_kill;
  assign clr_addr = (src == WB_SRC_LSU) ? lsu_waddr_i : pend_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 1; i < NUM_REGS; i++)
        regs[i] <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      if (wr.en)
        regs[wr.addr] <= wr.data;
      if (lsu_xfer && alu_we) begin
        pend_valid <= 1'b1;
        pend_addr  <= lsu_waddr_i;
        pend_data  <= lsu_wdata_i;
      end else if ((src == WB_SRC_PEND) || pend_kill) begin
        pend_valid <= 1'b0;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic              rst,
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   stored,
    input wb_write_t         w
  );
    if (rst || (addr == '0))              return '0;
    else if (w.en && (w.addr == addr))    return w.data;
    else                                  return stored;
  endfunction

  always_comb begin
    rs1_rdata_o = read_port(rst_i, rs1_addr_i, (rs1_addr_i == '0) ? '0 : regs[rs1_addr_i], wr);
    rs2_rdata_o = read_port(rst_i, rs2_addr_i, (rs2_addr_i == '0) ? '0 : regs[rs2_addr_i], wr);
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk_i),
    .rst      (rst_i),
    .set_en   (lsu_issue_i && !rst_i),
    .set_addr (lsu_issue_addr_i),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rs1_busy (rs1_busy_o),
    .rs2_busy (rs2_busy_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Table-driven bench for wb_regfile with an expected-result queue.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        alu_we_i;
  logic [4:0]  alu_waddr_i;
  logic [31:0] alu_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_issue_i;
  logic [4:0]  lsu_issue_addr_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] rs1_rdata_o, rs2_rdata_o;
  logic        rs1_busy_o, rs2_busy_o;

  wb_regfile dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .alu_we_i         (alu_we_i),
    .alu_waddr_i      (alu_waddr_i),
    .alu_wdata_i      (alu_wdata_i),
    .lsu_valid_i      (lsu_valid_i),
    .lsu_ready_o      (lsu_ready_o),
    .lsu_waddr_i      (lsu_waddr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_issue_i      (lsu_issue_i),
    .lsu_issue_addr_i (lsu_issue_addr_i),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .rs1_rdata_o      (rs1_rdata_o),
    .rs2_rdata_o      (rs2_rdata_o),
    .rs1_busy_o       (rs1_busy_o),
    .rs2_busy_o       (rs2_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        awe;
    logic [4:0]  aaddr;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  laddr;
    logic [31:0] ldata;
    logic        iss;
    logic [4:0]  iaddr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    int          tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(
    input logic rst, input logic awe, input logic [4:0] aaddr, input logic [31:0] adata,
    input logic lv, input logic [4:0] laddr, input logic [31:0] ldata,
    input logic iss, input logic [4:0] iaddr, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] e_rd1, input logic [31:0] e_rd2,
    input logic e_b1, input logic e_b2, input logic e_rdy);
    vec_t v;
    v.rst = rst; v.awe = awe; v.aaddr = aaddr; v.adata = adata;
    v.lv = lv; v.laddr = laddr; v.ldata = ldata; v.iss = iss; v.iaddr = iaddr;
    v.rs1 = rs1; v.rs2 = rs2; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
    v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Drives one cycle of stimulus just after posedge, checks outputs at negedge.
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    rst_i = v.rst; alu_we_i = v.awe; alu_waddr_i = v.aaddr; alu_wdata_i = v.adata;
    lsu_valid_i = v.lv; lsu_waddr_i = v.laddr; lsu_wdata_i = v.ldata;
    lsu_issue_i = v.iss; lsu_issue_addr_i = v.iaddr;
    rs1_addr_i = v.rs1; rs2_addr_i = v.rs2;
    exp_q.push_back('{tag: tag, rd1: v.e_rd1, rd2: v.e_rd2, b1: v.e_b1, b2: v.e_b2, rdy: v.e_rdy});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL queue_underflow vec=%0d got=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check("rs1_rdata", e.tag, rs1_rdata_o, e.rd1);
      check("rs2_rdata", e.tag, rs2_rdata_o, e.rd2);
      check("rs1_busy",  e.tag, {31'b0, rs1_busy_o}, {31'b0, e.b1});
      check("rs2_busy",  e.tag, {31'b0, rs2_busy_o}, {31'b0, e.b2});
      check("lsu_ready", e.tag, {31'b0, lsu_ready_o}, {31'b0, e.rdy});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst_i = 1'b1; alu_we_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
    lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
    lsu_issue_i = 1'b0; lsu_issue_addr_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // In reset: write rejected, reads zero, not ready.
    apply(mk(1, 1,5,32'hFFFF_FFFF, 1,6,32'h1111_1111, 0,0, 5,6, 0,0, 0,0, 0), 100);
    for (int i = 0; i < 16; i++)
      apply(mk(0, 0,0,0, 0,0,0, 0,0, 5'(2*i), 5'(2*i+1), 0,0, 0,0, 1), 200 + i);

    tbl.push_back(mk(0, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0, 32'hDEADBEEF,0, 0,0,1));
    tbl.push_back(mk(0, 1,0,32'h1234,     0,0,0, 0,0, 0,5, 0,32'hDEADBEEF, 0,0,1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0, 0,0, 0,5, 0,32'hDEADBEEF, 0,0,1));
    tbl.push_back(mk(0, 0,0,0,            0,0,0, 1,7, 7,0, 0,0, 0,0,1));
    tbl.push_back(mk(0, 1,3,32'h11, 1,7,32'hA5A5A5A5, 0,0, 3,7, 32'h11,0, 0,1,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 3,7, 32'h11,32'hA5A5A5A5, 0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 3,7, 32'h11,32'hA5A5A5A5, 0,0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,9, 9,7, 0,32'hA5A5A5A5, 0,0,1));
    tbl.push_back(mk(0, 1,4,32'h44, 1,9,32'h22, 0,0, 9,4, 0,32'h44, 1,0,1));
    tbl.push_back(mk(0, 1,9,32'h33, 0,0,0, 0,0, 9,4, 32'h33,32'h44, 0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 9,4, 32'h33,32'h44, 0,0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,10, 10,1, 0,0, 0,0,1));
    tbl.push_back(mk(0, 1,1,32'h1, 1,10,32'h55, 0,0, 10,1, 0,32'h1, 1,0,1));
    tbl.push_back(mk(0, 1,2,32'h2, 0,0,0, 0,0, 10,2, 0,32'h2, 1,0,0));
    tbl.push_back(mk(0, 1,1,32'h3, 0,0,0, 0,0, 10,1, 0,32'h3, 1,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 10,1, 32'h55,32'h3, 0,0,0));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 10,2, 32'h55,32'h2, 0,0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,12, 12,12, 0,0, 0,0,1));
    tbl.push_back(mk(0, 0,0,0, 1,12,32'h66, 1,12, 12,12, 32'h66,32'h66, 0,0,1));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 12,12, 32'h66,32'h66, 1,1,1));
    tbl.push_back(mk(0, 0,0,0, 1,0,32'hBAD, 0,0, 0,12, 0,32'h66, 0,1,1));
    foreach (tbl[i]) apply(tbl[i], i);

    // Reset while the holding buffer is full.
    apply(mk(0, 0,0,0, 0,0,0, 1,13, 13,14, 0,0, 0,0,1), 300);
    apply(mk(0, 1,14,32'h88, 1,13,32'h77, 0,0, 13,14, 0,32'h88, 1,0,1), 301);
    apply(mk(1, 1,5,32'h999, 0,0,0, 0,0, 14,0, 0,0, 0,0,0), 302);
    apply(mk(0, 0,0,0, 0,0,0, 0,0, 13,12, 0,0, 0,0,1), 303);
    apply(mk(0, 0,0,0, 0,0,0, 0,0, 14,5, 0,0, 0,0,1), 304);
    apply(mk(0, 0,0,0, 0,0,0, 0,0, 13,7, 0,0, 0,0,1), 305);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  synchronous reset, active high.
REQ-004 alu_we_i  input  1  ALU writeback enable; always accepted.
REQ-005 alu_waddr_i  input  5  ALU destination register.
REQ-006 alu_wdata_i  input  32  ALU result.
REQ-007 lsu_valid_i  input  1  load writeback valid.
REQ-008 lsu_ready_o  output  1  load writeback ready.
REQ-009 lsu_waddr_i  input  5  load destination register.
REQ-010 lsu_wdata_i  input  32  load data.
REQ-011 lsu_issue_i  input  1  load issued; marks destination busy.
REQ-012 lsu_issue_addr_i  input  5  destination register of the issued load.
REQ-013 rs1_addr_i, rs2_addr_i  input  5 each  read addresses.
REQ-014 rs1_rdata_o, rs2_rdata_o  output  32 each  read data.
REQ-015 rs1_busy_o, rs2_busy_o  output  1 each  source has an outstanding load.

Function
REQ-016 Storage SHALL be 31 x 32-bit registers x1..x31; x0 SHALL read 0, and writes to x0 SHALL be discarded.
REQ-017 Array writes SHALL take effect on the rising clk_i edge.
REQ-018 Reads SHALL be combinational with write-through: a read of an address being written this cycle returns the new data.
REQ-019 Write priority per cycle SHALL be: ALU write, then pending-buffer drain, then direct LSU write; at most one array write per cycle.
REQ-020 A one-entry pending buffer (pend_valid, addr, data) SHALL hold LSU data accepted while the ALU owns the write port.
REQ-021 lsu_ready_o SHALL equal !pend_valid; an LSU transfer occurs when lsu_valid_i && lsu_ready_o.
REQ-022 An LSU transfer without an ALU write SHALL write the array that cycle, with zero added latency.
REQ-023 An LSU transfer with an ALU write in the same cycle SHALL load the pending buffer (pend_valid=1 next cycle).
REQ-024 The pending buffer SHALL drain on the first cycle with alu_we_i=0 and SHALL stall for every cycle alu_we_i=1.
REQ-025 An ALU write to the pending entry's address (nonzero) SHALL discard the pending entry (younger write wins), and SHALL clear pend_valid next cycle.
REQ-026 Scoreboard: lsu_issue_i SHALL set busy[lsu_issue_addr_i] next cycle; address 0 SHALL never be busy.
REQ-027 A busy bit SHALL clear when the LSU write for that address is written to the array or discarded per REQ-025.
REQ-028 If a set and a clear of the same address occur in one cycle, the set SHALL win.
REQ-029 rsN_busy_o SHALL reflect registered busy bits, masked to 0 when the same-cycle clear of that address occurs.

Reset
REQ-030 On rst_i=1 at a clock edge: all registers 0, all busy bits 0, pend_valid=0.
REQ-031 During reset, lsu_ready_o SHALL be 0, no write SHALL be accepted, and read data SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL drop the pending entry without writing it.

Structure
REQ-033 Register-index width (5), XLEN (32) and NUM_REGS (32) SHALL be constants in milano_pkg.
REQ-034 The scoreboard SHALL be a sub-module named wb_scoreboard; storage, pending buffer and bypass stay in wb_regfile.

Verification
REQ-035 Reset, then read x0..x31 -> all 0; lsu_ready_o=1 one cycle after reset release.
REQ-036 ALU writes x5=0xDEADBEEF with rs1_addr_i=5 in the same cycle -> rs1_rdata_o=0xDEADBEEF that cycle; ALU write to x0=0x1234 -> x0 still reads 0.
REQ-037 LSU x7=0xA5A5A5A5 and ALU x3=0x11 in the same cycle -> x3=0x11 next cycle, lsu_ready_o=0 for one cycle, x7=0xA5A5A5A5 one cycle later.
REQ-038 Pending x9=0x22 while the ALU writes x9=0x33 -> x9=0x33, pending dropped, busy[9]=0.
REQ-039 Issue a load to x12, then issue again to x12 in the same cycle as the LSU write to x12 -> rs1_busy_o (rs1=12) stays 1.
REQ-040 Assert rst_i while pend_valid=1 -> pending data never written, all busy bits 0.
